// File: rtl/alu_issue_queue_if.sv
// Dispatch, CDB, ALU-issue and writeback signals of the ALU issue queue.
// The master side is the surrounding core; the slave side is the queue.
interface alu_issue_queue_if #(
  parameter int TAG_W = 6
);
  logic             dispatch_valid;
  logic             dispatch_ready;
  logic [4:0]       dispatch_aluop;
  logic [31:0]      dispatch_pc;
  logic [TAG_W-1:0] dispatch_dest_tag;
  logic [TAG_W-1:0] dispatch_src1_tag;
  logic [TAG_W-1:0] dispatch_src2_tag;
  logic             dispatch_src1_rdy;
  logic             dispatch_src2_rdy;
  logic [31:0]      dispatch_src1_val;
  logic [31:0]      dispatch_src2_val;
  logic             cdb_valid;
  logic [TAG_W-1:0] cdb_tag;
  logic [31:0]      cdb_data;
  logic             alu_en;
  logic [4:0]       alu_aluop;
  logic [31:0]      alu_a;
  logic [31:0]      alu_b;
  logic [31:0]      alu_pc;
  logic             wb_valid;
  logic [TAG_W-1:0] wb_tag;
  logic             wb_ack;

  modport master (
    output dispatch_valid, dispatch_aluop, dispatch_pc, dispatch_dest_tag,
           dispatch_src1_tag, dispatch_src2_tag, dispatch_src1_rdy, dispatch_src2_rdy,
           dispatch_src1_val, dispatch_src2_val, cdb_valid, cdb_tag, cdb_data, wb_ack,
    input  dispatch_ready, alu_en, alu_aluop, alu_a, alu_b, alu_pc, wb_valid, wb_tag
  );

  modport slave (
    input  dispatch_valid, dispatch_aluop, dispatch_pc, dispatch_dest_tag,
           dispatch_src1_tag, dispatch_src2_tag, dispatch_src1_rdy, dispatch_src2_rdy,
           dispatch_src1_val, dispatch_src2_val, cdb_valid, cdb_tag, cdb_data, wb_ack,
    output dispatch_ready, alu_en, alu_aluop, alu_a, alu_b, alu_pc, wb_valid, wb_tag
  );
endinterface

// File: rtl/alu_issue_queue.sv
// Collapsing reservation station for the registered ALU: oldest-ready issue,
// CDB operand capture, and tracking of the ALU result awaiting the CDB.
module alu_issue_queue #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 6
) (
  input logic clk,
  input logic rst,
  input logic flush,
  alu_issue_queue_if.slave bus
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = IDX_W + 1;

  typedef struct packed {
    logic [4:0]       aluop;
    logic [31:0]      pc;
    logic [TAG_W-1:0] dest;
    logic [TAG_W-1:0] s1_tag;
    logic             s1_rdy;
    logic [31:0]      s1_val;
    logic [TAG_W-1:0] s2_tag;
    logic             s2_rdy;
    logic [31:0]      s2_val;
  } entry_t;

  entry_t           ent_q [DEPTH];
  entry_t           ent_d [DEPTH];
  entry_t           disp_ent;
  entry_t           sel_ent;
  logic [CNT_W-1:0] count_q, count_d, count_rem;
  logic             wb_valid_q;
  logic [TAG_W-1:0] wb_tag_q;
  logic [IDX_W-1:0] sel;
  logic             found, can_issue, issue, accept;

  function automatic entry_t wake(entry_t e, logic v, logic [TAG_W-1:0] t, logic [31:0] d);
    entry_t r;
    r = e;
    if (v && !e.s1_rdy && e.s1_tag == t) begin
      r.s1_rdy = 1'b1;
      r.s1_val = d;
    end
    if (v && !e.s2_rdy && e.s2_tag == t) begin
      r.s2_rdy = 1'b1;
      r.s2_val = d;
    end
    return r;
  endfunction

  // Selection sees registered readiness only; scanning downward lets the oldest win.
  always_comb begin
    sel   = '0;
    found = 1'b0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (CNT_W'(i) < count_q && ent_q[i].s1_rdy && ent_q[i].s2_rdy) begin
        found = 1'b1;
        sel   = IDX_W'(i);
      end
    end
  end

  assign can_issue          = !flush && (!wb_valid_q || bus.wb_ack);
  assign issue              = can_issue && found;
  assign sel_ent            = ent_q[sel];
  assign bus.dispatch_ready = (count_q < CNT_W'(DEPTH));
  assign accept             = bus.dispatch_valid && bus.dispatch_ready && !flush;

  assign bus.alu_en    = issue;
  assign bus.alu_aluop = issue ? sel_ent.aluop  : '0;
  assign bus.alu_a     = issue ? sel_ent.s1_val : '0;
  assign bus.alu_b     = issue ? sel_ent.s2_val : '0;
  assign bus.alu_pc    = issue ? sel_ent.pc     : '0;
  assign bus.wb_valid  = wb_valid_q;
  assign bus.wb_tag    = wb_tag_q;

  always_comb begin
    disp_ent.aluop  = bus.dispatch_aluop;
    disp_ent.pc     = bus.dispatch_pc;
    disp_ent.dest   = bus.dispatch_dest_tag;
    disp_ent.s1_tag = bus.dispatch_src1_tag;
    disp_ent.s1_rdy = bus.dispatch_src1_rdy;
    disp_ent.s1_val = bus.dispatch_src1_val;
    disp_ent.s2_tag = bus.dispatch_src2_tag;
    disp_ent.s2_rdy = bus.dispatch_src2_rdy;
    disp_ent.s2_val = bus.dispatch_src2_val;
  end

  // Collapse over the issued slot (index wrap is harmless: the top slot becomes invalid).
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      if (issue && IDX_W'(i) >= sel)
        ent_d[i] = wake(ent_q[IDX_W'(i + 1)], bus.cdb_valid, bus.cdb_tag, bus.cdb_data);
      else
        ent_d[i] = wake(ent_q[i], bus.cdb_valid, bus.cdb_tag, bus.cdb_data);
    end
    count_rem = count_q - CNT_W'(issue);
    if (accept)
      ent_d[count_rem[IDX_W-1:0]] = wake(disp_ent, bus.cdb_valid, bus.cdb_tag, bus.cdb_data);
    count_d = count_rem + CNT_W'(accept);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ent_q      <= '{default: '0};
      count_q    <= '0;
      wb_valid_q <= 1'b0;
      wb_tag_q   <= '0;
    end else if (flush) begin
      count_q    <= '0;
      wb_valid_q <= 1'b0;
    end else begin
      ent_q   <= ent_d;
      count_q <= count_d;
      if (issue) begin
        wb_valid_q <= 1'b1;
        wb_tag_q   <= sel_ent.dest;
      end else if (bus.wb_ack) begin
        wb_valid_q <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_alu_issue_queue.sv
// Directed scenarios plus random traffic against a queue-based model of the
// issue queue: oldest-ready issue, CDB capture, writeback handshake, flush, reset.
module tb_alu_issue_queue;
  localparam int DEPTH = 4;
  localparam int TAG_W = 6;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic flush = 1'b0;
  always #5 clk = ~clk;

  alu_issue_queue_if #(.TAG_W(TAG_W)) bus();

  alu_issue_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk(clk),
    .rst(rst),
    .flush(flush),
    .bus(bus.slave)
  );

  typedef struct {
    logic [4:0]       op;
    logic [31:0]      pc;
    logic [TAG_W-1:0] dest;
    logic [TAG_W-1:0] t1;
    bit               r1;
    logic [31:0]      v1;
    logic [TAG_W-1:0] t2;
    bit               r2;
    logic [31:0]      v2;
  } m_ent;

  m_ent             q[$];
  bit               mwbv;
  logic [TAG_W-1:0] mwbt;
  bit               m_iss;
  int               m_idx;
  int               total = 0;
  int               bad = 0;

  logic             seen_en, seen_rdy, seen_wbv;
  logic [31:0]      seen_a, seen_b;
  logic [TAG_W-1:0] seen_wbt;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic m_ent mwake(m_ent e, logic cv, logic [TAG_W-1:0] ct, logic [31:0] cd);
    m_ent r = e;
    if (cv && !e.r1 && e.t1 == ct) begin r.r1 = 1'b1; r.v1 = cd; end
    if (cv && !e.r2 && e.t2 == ct) begin r.r2 = 1'b1; r.v2 = cd; end
    return r;
  endfunction

  task automatic check_outputs();
    m_ent e = '{default: '0};
    m_iss = 1'b0;
    m_idx = 0;
    if (rst && !flush && (!mwbv || bus.wb_ack)) begin
      for (int k = 0; k < q.size(); k++) begin
        if (!m_iss && q[k].r1 && q[k].r2) begin
          m_iss = 1'b1;
          m_idx = k;
        end
      end
    end
    if (m_iss) e = q[m_idx];
    chk("alu_en",         bus.alu_en,         m_iss);
    chk("alu_aluop",      bus.alu_aluop,      e.op);
    chk("alu_a",          bus.alu_a,          e.v1);
    chk("alu_b",          bus.alu_b,          e.v2);
    chk("alu_pc",         bus.alu_pc,         e.pc);
    chk("dispatch_ready", bus.dispatch_ready, q.size() < DEPTH);
    chk("wb_valid",       bus.wb_valid,       mwbv);
    chk("wb_tag",         bus.wb_tag,         mwbt);
  endtask

  task automatic update_model();
    bit   acc;
    m_ent n;
    if (!rst) begin
      q.delete();
      mwbv = 1'b0;
      mwbt = '0;
    end else if (flush) begin
      q.delete();
      mwbv = 1'b0;
    end else begin
      acc = bus.dispatch_valid && (q.size() < DEPTH);
      if (m_iss) begin
        mwbv = 1'b1;
        mwbt = q[m_idx].dest;
        q.delete(m_idx);
      end else if (bus.wb_ack) begin
        mwbv = 1'b0;
      end
      foreach (q[k]) q[k] = mwake(q[k], bus.cdb_valid, bus.cdb_tag, bus.cdb_data);
      if (acc) begin
        n.op = bus.dispatch_aluop;      n.pc = bus.dispatch_pc;
        n.dest = bus.dispatch_dest_tag;
        n.t1 = bus.dispatch_src1_tag;   n.r1 = bus.dispatch_src1_rdy;
        n.v1 = bus.dispatch_src1_val;
        n.t2 = bus.dispatch_src2_tag;   n.r2 = bus.dispatch_src2_rdy;
        n.v2 = bus.dispatch_src2_val;
        q.push_back(mwake(n, bus.cdb_valid, bus.cdb_tag, bus.cdb_data));
      end
    end
  endtask

  // Called just after a falling edge with inputs already driven.
  task automatic step();
    #1;
    check_outputs();
    seen_en  = bus.alu_en;
    seen_a   = bus.alu_a;
    seen_b   = bus.alu_b;
    seen_rdy = bus.dispatch_ready;
    seen_wbv = bus.wb_valid;
    seen_wbt = bus.wb_tag;
    @(posedge clk);
    update_model();
    @(negedge clk);
  endtask

  task automatic disp(logic [4:0] op, logic [31:0] pc, logic [TAG_W-1:0] dest,
                      logic [TAG_W-1:0] t1, bit r1, logic [31:0] v1,
                      logic [TAG_W-1:0] t2, bit r2, logic [31:0] v2);
    bus.dispatch_valid = 1'b1;
    bus.dispatch_aluop = op;       bus.dispatch_pc = pc;
    bus.dispatch_dest_tag = dest;
    bus.dispatch_src1_tag = t1;    bus.dispatch_src1_rdy = r1;  bus.dispatch_src1_val = v1;
    bus.dispatch_src2_tag = t2;    bus.dispatch_src2_rdy = r2;  bus.dispatch_src2_val = v2;
  endtask

  task automatic cdb(bit v, logic [TAG_W-1:0] t, logic [31:0] d);
    bus.cdb_valid = v;
    bus.cdb_tag   = t;
    bus.cdb_data  = d;
  endtask

  task automatic idle();
    bus.dispatch_valid = 1'b0;
    cdb(1'b0, '0, '0);
    flush = 1'b0;
  endtask

  task automatic randomize_inputs();
    flush = ($urandom_range(0, 49) == 0);
    disp(5'($urandom_range(0, 31)), $urandom, 6'($urandom_range(0, 63)),
         6'($urandom_range(0, 7)), bit'($urandom_range(0, 1)), $urandom,
         6'($urandom_range(0, 7)), bit'($urandom_range(0, 1)), $urandom);
    bus.dispatch_valid = ($urandom_range(0, 2) != 0);
    cdb(bit'($urandom_range(0, 1)), 6'($urandom_range(0, 7)), $urandom);
    bus.wb_ack = ($urandom_range(0, 3) != 0);
  endtask

  initial begin
    q.delete();
    mwbv = 1'b0;
    mwbt = '0;
    disp('0, '0, '0, '0, 1'b0, '0, '0, 1'b0, '0);
    idle();
    bus.wb_ack = 1'b1;
    @(negedge clk);
    repeat (2) step();
    rst = 1'b1;

    // Ready op: issues the cycle after dispatch, result tag visible one cycle later.
    disp(5'd0, 32'h100, 6'd9, 6'd1, 1'b1, 32'd5, 6'd2, 1'b1, 32'd7);
    step();
    idle();
    step();
    chk("add_en", seen_en, 1);
    chk("add_a",  seen_a,  5);
    chk("add_b",  seen_b,  7);
    step();
    chk("add_wbv", seen_wbv, 1);
    chk("add_wbt", seen_wbt, 9);

    // Younger ready op overtakes an older waiting one; CDB then releases the older.
    disp(5'd1, 32'h104, 6'd10, 6'd3, 1'b0, 32'd0, 6'd20, 1'b1, 32'd1);
    step();
    disp(5'd2, 32'h108, 6'd11, 6'd21, 1'b1, 32'd2, 6'd22, 1'b1, 32'd3);
    step();
    idle();
    step();
    chk("order_en", seen_en, 1);
    chk("order_a",  seen_a,  2);
    cdb(1'b1, 6'd3, 32'h10);
    step();
    chk("wait_en", seen_en, 0);
    idle();
    step();
    chk("wake_en", seen_en, 1);
    chk("wake_a",  seen_a,  32'h10);

    // CDB value captured by the op being dispatched in the same cycle.
    disp(5'd3, 32'h10c, 6'd12, 6'd23, 1'b1, 32'd3, 6'd4, 1'b0, 32'd0);
    cdb(1'b1, 6'd4, 32'hFF);
    step();
    idle();
    step();
    chk("byp_en", seen_en, 1);
    chk("byp_b",  seen_b,  32'hFF);

    // Backpressure until full, then one ack releases exactly one issue.
    repeat (2) step();
    bus.wb_ack = 1'b0;
    disp(5'd4, 32'h110, 6'd13, 6'd1, 1'b1, 32'd1, 6'd2, 1'b1, 32'd1);
    step();
    idle();
    step();
    chk("bp_first", seen_en, 1);
    for (int k = 0; k < DEPTH; k++) begin
      disp(5'd5, 32'h200 + 32'(k), 6'(14 + k), 6'd1, 1'b1, 32'(k), 6'd2, 1'b1, 32'(k));
      step();
    end
    disp(5'd6, 32'h300, 6'd18, 6'd1, 1'b1, 32'd0, 6'd2, 1'b1, 32'd0);
    step();
    chk("full_rdy", seen_rdy, 0);
    chk("bp_en",    seen_en,  0);
    chk("bp_wbt",   seen_wbt, 13);
    idle();
    bus.wb_ack = 1'b1;
    step();
    chk("bp_issue", seen_en, 1);
    bus.wb_ack = 1'b0;
    step();
    chk("bp_wbt2", seen_wbt, 14);

    // Flush with three entries and a pending result; same-cycle dispatch is dropped.
    flush = 1'b1;
    disp(5'd7, 32'h400, 6'd19, 6'd1, 1'b1, 32'd0, 6'd2, 1'b1, 32'd0);
    step();
    chk("fl_cyc_en", seen_en, 0);
    idle();
    step();
    chk("fl_wbv", seen_wbv, 0);
    chk("fl_rdy", seen_rdy, 1);
    chk("fl_en",  seen_en,  0);
    bus.wb_ack = 1'b1;
    step();
    chk("fl_drop", seen_en, 0);

    // Random traffic with a reset held for three cycles in the middle.
    for (int c = 0; c < 3000; c++) begin
      if (c == 1500) begin
        rst = 1'b0;
        q.delete();
        mwbv = 1'b0;
        mwbt = '0;
        repeat (3) begin
          randomize_inputs();
          step();
        end
        rst = 1'b1;
        idle();
        step();
        chk("rst_wbv", seen_wbv, 0);
        chk("rst_en",  seen_en,  0);
        chk("rst_rdy", seen_rdy, 1);
      end
      randomize_inputs();
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
